// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multi-cycle MIPS subset core with one shared req/ready memory port.
// Define MIPS_MC_PERF_EN to add the perf_cycles/perf_instret counters.
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC = 32'h00003000,
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        halted,
    output logic [1:0]  trap_cause,
    output logic [31:0] DATA,
    output logic [31:0] ADDRESS
`ifdef MIPS_MC_PERF_EN
    ,
    output logic [31:0] perf_cycles,
    output logic [31:0] perf_instret
`endif
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2b;

    state_t      state;
    logic [31:0] pc, ir, a, b, alu_out, mdr, wait_cnt;
    logic [1:0]  cause;
    logic [31:0] rf [32];
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt, wb_reg;
    logic [31:0] imm, alu, wb_val;
    logic        is_r, is_mem, legal, timeout;

    always_comb begin
        op      = ir[31:26];
        rs      = ir[25:21];
        rt      = ir[20:16];
        rd      = ir[15:11];
        shamt   = ir[10:6];
        funct   = ir[5:0];
        imm     = {{16{ir[15]}}, ir[15:0]};
        is_r    = op == OP_R;
        is_mem  = op == OP_LW || op == OP_SW;
        legal   = is_r ? funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h02}
                       : op inside {OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW};
        alu     = !is_r ? a + imm :
                  funct == 6'h20 ? a + b :
                  funct == 6'h22 ? a - b :
                  funct == 6'h24 ? a & b :
                  funct == 6'h25 ? a | b :
                  funct == 6'h2a ? {31'd0, $signed(a) < $signed(b)} :
                  funct == 6'h00 ? b << shamt : b >> shamt;
        wb_reg  = is_r ? rd : rt;
        wb_val  = op == OP_LW ? mdr : alu_out;
        timeout = WAIT_MAX != 0 && wait_cnt == WAIT_MAX - 1;
    end

    // Requests are gated by RESET so an access in flight drops the instant reset asserts.
    assign mem_req    = RESET && (state == FETCH || state == MEM);
    assign mem_we     = mem_req && state == MEM && op == OP_SW;
    assign mem_addr   = !mem_req ? 32'd0 : state == FETCH ? {pc[31:2], 2'b00} : {alu_out[31:2], 2'b00};
    assign mem_wdata  = mem_we ? b : 32'd0;
    assign halted     = state == TRAP;
    assign trap_cause = cause;
    assign DATA       = state == WB && wb_reg != 5'd0 ? wb_val : 32'd0;
    assign ADDRESS    = pc;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= FETCH;
            pc    <= RESET_PC;
            {ir, a, b, alu_out, mdr, wait_cnt} <= '0;
            cause <= 2'b00;
        end else begin
            case (state)
                FETCH, MEM: begin
                    if (mem_ready) begin
                        wait_cnt <= '0;
                        if (state == FETCH) begin
                            ir <= mem_rdata;
                            pc <= pc + 32'd4;
                        end else mdr <= mem_rdata;
                        state <= state == FETCH ? DECODE : op == OP_SW ? FETCH : WB;
                    end else if (timeout) begin
                        state <= TRAP;
                        cause <= 2'b10;
                    end else wait_cnt <= wait_cnt + 32'd1;
                end
                DECODE: begin
                    a     <= rf[rs];
                    b     <= rf[rt];
                    state <= !legal ? TRAP : op == OP_J ? FETCH : EXEC;
                    if (!legal) cause <= 2'b01;
                    else if (op == OP_J) pc <= {pc[31:28], ir[25:0], 2'b00};
                end
                EXEC: begin
                    alu_out <= alu;
                    if (op == OP_BEQ) begin
                        if (a == b) pc <= pc + {imm[29:0], 2'b00};
                        state <= FETCH;
                    end else if (is_mem && alu[1:0] != 2'b00) begin
                        state <= TRAP;
                        cause <= 2'b11;
                    end else state <= is_mem ? MEM : WB;
                end
                WB: state <= FETCH;
                default: state <= TRAP;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (state == WB && wb_reg != 5'd0) rf[wb_reg] <= wb_val;
    end

`ifdef MIPS_MC_PERF_EN
    logic retire;
    assign retire = state == WB || (state == DECODE && legal && op == OP_J) ||
                    (state == EXEC && op == OP_BEQ) || (state == MEM && mem_ready && op == OP_SW);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            perf_cycles  <= '0;
            perf_instret <= '0;
        end else begin
            if (state != TRAP) perf_cycles <= perf_cycles + 32'd1;
            if (retire) perf_instret <= perf_instret + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb_mips_multicycle_core: directed vector table plus hand sequences for stalls, traps and reset.
module tb_mips_multicycle_core;
    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        mem_req, mem_we, mem_ready, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, DATA, ADDRESS;
    logic [1:0]  trap_cause;
`ifdef MIPS_MC_PERF_EN
    logic [31:0] perf_cycles, perf_instret;
`endif

    mips_multicycle_core #(.RESET_PC(32'h00003000), .WAIT_MAX(4)) dut (
        .CLK(CLK), .RESET(RESET), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .halted(halted),
        .trap_cause(trap_cause), .DATA(DATA), .ADDRESS(ADDRESS)
`ifdef MIPS_MC_PERF_EN
        , .perf_cycles(perf_cycles), .perf_instret(perf_instret)
`endif
    );

    always #5 CLK = ~CLK;

    logic [31:0] img [4096];
    logic [31:0] mem [4096];
    int          stall, wait_cfg, wr_cnt;
    logic        mute;
    logic [31:0] wr_addr, wr_data;
    int          cyc, total, passed;

    // Memory image is copied in while reset is held; ready comes after wait_cfg stall cycles.
    assign mem_ready = mem_req && !mute && stall == wait_cfg;
    assign mem_rdata = mem[mem_addr[13:2]];

    always @(posedge CLK) begin
        if (!RESET) begin
            for (int i = 0; i < 4096; i++) mem[i] <= img[i];
            stall   <= 0;
            wr_cnt  <= 0;
            wr_addr <= 32'd0;
            wr_data <= 32'd0;
        end else if (mem_req && mem_ready) begin
            stall <= 0;
            if (mem_we) begin
                mem[mem_addr[13:2]] <= mem_wdata;
                wr_cnt  <= wr_cnt + 1;
                wr_addr <= mem_addr;
                wr_data <= mem_wdata;
            end
        end else if (mem_req) stall <= stall + 1;
    end

    function automatic logic [31:0] enc_r(input logic [5:0] f, input logic [4:0] s, input logic [4:0] t,
                                          input logic [4:0] d, input logic [4:0] sh);
        return {6'h00, s, t, d, sh, f};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t,
                                          input logic [15:0] im);
        return {o, s, t, im};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] tg);
        return {6'h02, tg};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic clr_img();
        for (int i = 0; i < 4096; i++) img[i] = 32'd0;
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        cyc = 0;
    endtask

    task automatic goto(input int k);
        while (cyc < k) begin
            @(negedge CLK);
            cyc++;
        end
    endtask

    typedef struct {
        logic [15:0] ia;
        logic [15:0] ib;
        logic [31:0] instr;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [10];

    initial begin
        total = 0; passed = 0; cyc = 0; wait_cfg = 0; mute = 1'b0;
        vecs[0] = '{16'h0005, 16'h0007, enc_r(6'h20, 5'd1, 5'd2, 5'd3, 5'd0), 32'h0000000C};
        vecs[1] = '{16'h0005, 16'h0007, enc_r(6'h22, 5'd1, 5'd2, 5'd3, 5'd0), 32'hFFFFFFFE};
        vecs[2] = '{16'h00FF, 16'h0F0F, enc_r(6'h24, 5'd1, 5'd2, 5'd3, 5'd0), 32'h0000000F};
        vecs[3] = '{16'h00FF, 16'h0F0F, enc_r(6'h25, 5'd1, 5'd2, 5'd3, 5'd0), 32'h00000FFF};
        vecs[4] = '{16'hFFFF, 16'h0001, enc_r(6'h2a, 5'd1, 5'd2, 5'd3, 5'd0), 32'h00000001};
        vecs[5] = '{16'h0001, 16'hFFFF, enc_r(6'h2a, 5'd1, 5'd2, 5'd3, 5'd0), 32'h00000000};
        vecs[6] = '{16'h0005, 16'h0123, enc_r(6'h00, 5'd0, 5'd2, 5'd3, 5'd4), 32'h00001230};
        vecs[7] = '{16'h8000, 16'h0001, enc_r(6'h02, 5'd0, 5'd1, 5'd3, 5'd8), 32'h00FFFF80};
        vecs[8] = '{16'h0005, 16'h0007, enc_i(6'h08, 5'd1, 5'd3, 16'hFFFD), 32'h00000002};
        vecs[9] = '{16'h8000, 16'h8000, enc_r(6'h20, 5'd1, 5'd2, 5'd3, 5'd0), 32'hFFFF0000};

        // Reset values, first fetch, the three-instruction program and an asynchronous reset mid-fetch.
        clr_img();
        img['hC00] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        img['hC01] = enc_i(6'h08, 5'd0, 5'd2, 16'd7);
        img['hC02] = enc_r(6'h20, 5'd1, 5'd2, 5'd3, 5'd0);
        repeat (2) @(negedge CLK);
        chk("rst ADDRESS", ADDRESS, 32'h00003000);
        chk("rst mem_req", 32'(mem_req), 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst mem_wdata", mem_wdata, 32'd0);
        chk("rst halted", 32'(halted), 32'd0);
        chk("rst trap_cause", 32'(trap_cause), 32'd0);
        chk("rst DATA", DATA, 32'd0);
        RESET = 1'b1;
        cyc = 0;
        #1;
        chk("fetch req", 32'(mem_req), 32'd1);
        chk("fetch addr", mem_addr, 32'h00003000);
        chk("fetch we", 32'(mem_we), 32'd0);
        goto(3);  chk("prog DATA 5", DATA, 32'd5);
        goto(7);  chk("prog DATA 7", DATA, 32'd7);
        goto(10); chk("prog DATA exec", DATA, 32'd0);
        goto(11); chk("prog DATA 12", DATA, 32'd12);
        goto(12); chk("prog ADDRESS", ADDRESS, 32'h0000300C);
`ifdef MIPS_MC_PERF_EN
        chk("perf_instret 3", perf_instret, 32'd3);
        chk("perf_cycles 12", perf_cycles, 32'd12);
`endif
        mute = 1'b1;
        goto(13);
        chk("stall req held", 32'(mem_req), 32'd1);
        chk("stall addr held", mem_addr, 32'h0000300C);
        #2 RESET = 1'b0;
        #1;
        chk("async rst req", 32'(mem_req), 32'd0);
        chk("async rst addr", mem_addr, 32'd0);
        chk("async rst ADDRESS", ADDRESS, 32'h00003000);
`ifdef MIPS_MC_PERF_EN
        chk("async rst cycles", perf_cycles, 32'd0);
        chk("async rst instret", perf_instret, 32'd0);
`endif
        mute = 1'b0;

        for (int i = 0; i < 10; i++) begin
            clr_img();
            img['hC00] = enc_i(6'h08, 5'd0, 5'd1, vecs[i].ia);
            img['hC01] = enc_i(6'h08, 5'd0, 5'd2, vecs[i].ib);
            img['hC02] = vecs[i].instr;
            do_reset();
            goto(3);  chk($sformatf("v%0d r1", i), DATA, {{16{vecs[i].ia[15]}}, vecs[i].ia});
            goto(7);  chk($sformatf("v%0d r2", i), DATA, {{16{vecs[i].ib[15]}}, vecs[i].ib});
            goto(10); chk($sformatf("v%0d exec", i), DATA, 32'd0);
            goto(11); chk($sformatf("v%0d result", i), DATA, vecs[i].exp);
            goto(12); chk($sformatf("v%0d pc", i), ADDRESS, 32'h0000300C);
            chk($sformatf("v%0d next fetch", i), mem_addr, 32'h0000300C);
        end

        // sw then lw through a memory with three wait cycles per access.
        clr_img();
        img['hC00] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        img['hC01] = enc_i(6'h08, 5'd0, 5'd2, 16'd7);
        img['hC02] = enc_r(6'h20, 5'd1, 5'd2, 5'd3, 5'd0);
        img['hC03] = enc_i(6'h2b, 5'd0, 5'd3, 16'h0040);
        img['hC04] = enc_i(6'h23, 5'd0, 5'd4, 16'h0040);
        wait_cfg = 3;
        do_reset();
        goto(20); chk("ws add DATA", DATA, 32'd12);
        goto(28);
        chk("sw req", 32'(mem_req), 32'd1);
        chk("sw we", 32'(mem_we), 32'd1);
        chk("sw addr", mem_addr, 32'h00000040);
        chk("sw wdata", mem_wdata, 32'd12);
        goto(31);
        chk("sw count", 32'(wr_cnt), 32'd1);
        chk("sw wr_addr", wr_addr, 32'h00000040);
        chk("sw wr_data", wr_data, 32'd12);
        goto(38);
        chk("lw req", 32'(mem_req), 32'd1);
        chk("lw we", 32'(mem_we), 32'd0);
        chk("lw addr", mem_addr, 32'h00000040);
        goto(40); chk("lw early DATA", DATA, 32'd0);
        goto(41); chk("lw DATA", DATA, 32'd12);
        goto(42); chk("lw next pc", ADDRESS, 32'h00003014);
        wait_cfg = 0;

        // j to 0x3010, then beq r1,r1,-1 loops back to itself.
        clr_img();
        img['hC00] = enc_j(26'h0000C04);
        img['hC04] = enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF);
        do_reset();
        goto(2); chk("j target", ADDRESS, 32'h00003010);
        goto(3); chk("beq fetched", ADDRESS, 32'h00003014);
        goto(5); chk("beq taken", ADDRESS, 32'h00003010);
        chk("beq refetch", mem_addr, 32'h00003010);

        clr_img();
        img['hC00] = enc_j(26'h0000C00);
        do_reset();
        goto(1); chk("j fetched", ADDRESS, 32'h00003004);
        goto(2); chk("j self", ADDRESS, 32'h00003000);

        clr_img();
        img['hC00] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
        img['hC01] = enc_i(6'h04, 5'd0, 5'd1, 16'd5);
        do_reset();
        goto(7); chk("beq not taken", ADDRESS, 32'h00003008);

        // Traps: illegal opcode, illegal funct, misaligned lw, memory timeout.
        clr_img();
        img['hC00] = 32'hFC000000;
        do_reset();
        goto(1); chk("ill op running", 32'(halted), 32'd0);
        goto(2);
        chk("ill op halted", 32'(halted), 32'd1);
        chk("ill op cause", 32'(trap_cause), 32'd1);
        chk("ill op req", 32'(mem_req), 32'd0);

        clr_img();
        img['hC00] = enc_r(6'h3f, 5'd0, 5'd0, 5'd0, 5'd0);
        do_reset();
        goto(2); chk("ill funct cause", 32'(trap_cause), 32'd1);

        clr_img();
        img['hC00] = enc_i(6'h23, 5'd0, 5'd4, 16'h0042);
        do_reset();
        goto(3);
        chk("misalign halted", 32'(halted), 32'd1);
        chk("misalign cause", 32'(trap_cause), 32'd3);
        chk("misalign req", 32'(mem_req), 32'd0);

        clr_img();
        mute = 1'b1;
        do_reset();
        goto(3);
        chk("timeout pending", 32'(halted), 32'd0);
        chk("timeout req", 32'(mem_req), 32'd1);
        goto(4);
        chk("timeout halted", 32'(halted), 32'd1);
        chk("timeout cause", 32'(trap_cause), 32'd2);
        chk("timeout pc", ADDRESS, 32'h00003000);
        chk("timeout req drop", 32'(mem_req), 32'd0);
        mute = 1'b0;
        goto(9);
        chk("trap holds", 32'(halted), 32'd1);
        chk("trap cause holds", 32'(trap_cause), 32'd2);
`ifdef MIPS_MC_PERF_EN
        chk("trap cycles frozen", perf_cycles, 32'd4);
        chk("trap instret", perf_instret, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_core.md
Name: mips_multicycle_core

Overview:
- Multi-cycle successor of the team's single-cycle MIPS datapath: one instruction is processed over 4-5 states and shares a single external memory port for instruction and data.
- The memory port uses a req/ready handshake, so slow memories stall the core cleanly.
- Contains its own 32x32 register file (r0 hardwired to 0), ALU and control FSM.
- Sits between the board top and a unified memory or bus adapter; exposes debug DATA/ADDRESS as before.

Parameters:
- RESET_PC, 32'h00003000, PC value loaded on reset.
- WAIT_MAX, 255, maximum stall cycles per memory access before the core traps; 0 disables the timeout.

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-low reset
- mem_req  out  1  memory access request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  32  byte address, bits [1:0] always 0
- mem_wdata  out  32  store data
- mem_rdata  in  32  read data, valid when mem_ready=1
- mem_ready  in  1  access complete this cycle
- halted  out  1  core stopped in TRAP
- trap_cause  out  2  00 none, 01 illegal op, 10 memory timeout, 11 misaligned
- DATA  out  32  value written to the register file this cycle, else 0
- ADDRESS  out  32  current PC

Behaviour:
- Reset (RESET=0, asynchronous):
  - PC=RESET_PC, state=FETCH; all registers 0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0, trap_cause=0, DATA=0.
- Supported instructions:
  - R-type: add, sub, and, or, slt, sll, srl (shift amount = Instr[10:6]).
  - I-type: addi, lw, sw, beq.
  - J-type: j.
  - Any other opcode/funct traps as illegal op.
- Arithmetic: 32-bit wrap-around, no overflow exceptions; slt is signed; immediates are sign-extended.
- Handshake rules:
  - mem_req is held high with stable addr/we/wdata until the cycle mem_ready=1.
  - The access completes in that cycle.
  - mem_req drops in the next cycle unless a new access begins immediately.
  - mem_ready while mem_req=0 is ignored.
- FSM states and transitions:
  - FETCH: req, addr=PC, we=0. On ready: IR<=mem_rdata, PC<=PC+4 → DECODE.
  - DECODE: A<=rf[rs], B<=rf[rt].
    - j: PC<={PC[31:28],IR[25:0],2'b00} → FETCH.
    - Illegal: → TRAP.
    - Otherwise → EXEC.
  - EXEC: ALUOut<=ALU(A, B or SignImm).
    - beq: if A==B then PC<=PC+(SignImm<<2) → FETCH.
    - lw/sw: if ALU result[1:0]≠0 → TRAP (misaligned), else → MEM.
    - R-type/addi → WB.
  - MEM: req, addr=ALUOut.
    - sw: we=1, wdata=B; on ready → FETCH.
    - lw: on ready MDR<=mem_rdata → WB.
  - WB: rf[rd or rt]<=ALUOut or MDR; writes to r0 are discarded. DATA shows the value for this one cycle. → FETCH.
  - TRAP: halted=1, mem_req=0, trap_cause holds; left only by reset.
- Latency with zero-wait memory:
  - R-type/addi 4 cycles; lw 5; sw 4; beq 3; j 2.
  - Each wait cycle adds 1.
- Timeout: a stall counter clears on each new access. When WAIT_MAX≠0 and the counter reaches WAIT_MAX without ready: → TRAP, cause 10, PC unchanged.
- A reset in the middle of an access drops mem_req asynchronously; no write is considered committed.
- PC wraps modulo 2^32.

Optional Feature:
- Macro: MIPS_MC_PERF_EN.
- Defined:
  - Adds ports perf_cycles (out, 32) and perf_instret (out, 32).
  - perf_cycles increments every cycle except in TRAP.
  - perf_instret increments on each transition into FETCH from DECODE/EXEC/MEM/WB, i.e. one per completed instruction.
  - Both reset to 0 and wrap.
- Undefined: the ports, the counters and their logic are absent.

Test Plan:
- Reset with RESET_PC=32'h00003000 → ADDRESS=32'h00003000, mem_req=0. First FETCH: mem_addr=32'h00003000.
- Zero-wait memory, program "addi r1,r0,5; addi r2,r0,7; add r3,r1,r2" → DATA=5, 7, 12 in the respective WB cycles; 12 total cycles.
- sw r3,0x40(r0) then lw r4,0x40(r0), memory with 3 wait cycles → write seen at addr 0x40 with data 12; r4=12; lw takes 5+6=11 cycles.
- beq r1,r1,-1 at PC=0x3010 → PC returns to 0x3010 after 3 cycles. j 0x0000C00 → PC=0x00003000.
- Illegal opcode 6'h3F → halted=1, trap_cause=01. Memory never answering with WAIT_MAX=4 → halted after 4 stall cycles, cause 10. lw at address 0x42 → cause 11.
- With MIPS_MC_PERF_EN, run the 3-instruction program → perf_instret=3, perf_cycles=12. Assert RESET mid-FETCH → both counters 0, mem_req=0 immediately.
